hazard_fwd_unit: RTL and testbench

- Consumer end of the decode-stage source/destination interface.
- Takes src1, src2, Dest, WB_EN and MEM_R_EN for the instruction now in ID.
- Tracks the destinations of older instructions still in EXE, MEM and WB in an internal slot pipeline.
- Drives a stall request (hazard_detected) back to IF/ID, and drives registered forwarding selects for the instruction entering EXE.

---
 rtl/hazard_fwd_unit_pkg.sv | 32 +++
 rtl/hazard_fwd_unit_if.sv | 28 ++
 rtl/hazard_fwd_unit_slot_pipe.sv | 28 ++
 rtl/hazard_fwd_unit.sv | 112 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the decode-stage hazard / forwarding unit: forwarding
// select encoding, the in-flight slot record and the "slot writes r" test.
package hazard_pkg;

  // Slots store register numbers zero-extended to a fixed width so the record
  // type stays independent of the unit's REG_ADDR_W parameter (up to 8 bits).
  localparam int SLOT_DEST_W = 8;

  typedef logic [SLOT_DEST_W-1:0] slot_dest_t;

  localparam slot_dest_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    slot_dest_t dest;
    logic       wb_en;
    logic       mem_r;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  function automatic logic slot_writes(slot_t s, slot_dest_t r);
    return s.valid && s.wb_en && (s.dest == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-stage source/destination bus: ID instruction fields toward the
// hazard unit, stall request and forwarding selects back.
interface hazard_fwd_if #(
  parameter int REG_ADDR_W = 5
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  logic                  hazard_detected;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
    input  hazard_detected, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
    output hazard_detected, fwd_sel1, fwd_sel2
  );

endinterface

// File: rtl/hazard_fwd_unit_slot_pipe.sv
// Three-slot shadow of the EXE/MEM/WB destinations: shifts on every unfrozen
// edge, with a bubble injected into EXE on request.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  freeze,
  input  logic  bubble,
  input  slot_t entry,
  output slot_t exe,
  output slot_t mem,
  output slot_t wb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      exe <= SLOT_BUBBLE;
      mem <= SLOT_BUBBLE;
      wb  <= SLOT_BUBBLE;
    end else if (!freeze) begin
      wb  <= mem;
      mem <= exe;
      exe <= bubble ? SLOT_BUBBLE : entry;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding-select generation for the instruction in ID,
// comparing its sources against older producers still in EXE and MEM.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  input logic         fwd_en,
  input logic         freeze,
  hazard_fwd_if.slave bus
);

  function automatic slot_dest_t widen(logic [REG_ADDR_W-1:0] r);
    return slot_dest_t'(r);
  endfunction

  slot_t      exe_slot;
  slot_t      mem_slot;
  slot_t      wb_slot;
  slot_t      entry;
  slot_dest_t src1;
  slot_dest_t src2;
  logic       src1_matters;
  logic       src2_matters;
  logic       exe_w1, exe_w2, mem_w1, mem_w2;
  logic       hazard;
  logic       bubble;
  fwd_sel_t   sel1_next, sel2_next;
  fwd_sel_t   sel1_q, sel2_q;
  logic       unused_ok;

  assign src1 = widen(bus.id_src1);
  assign src2 = widen(bus.id_src2);

  assign src1_matters = bus.id_valid && (src1 != REG_ZERO);
  assign src2_matters = bus.id_valid && bus.id_two_src && (src2 != REG_ZERO);

  assign exe_w1 = slot_writes(exe_slot, src1);
  assign exe_w2 = slot_writes(exe_slot, src2);
  assign mem_w1 = slot_writes(mem_slot, src1);
  assign mem_w2 = slot_writes(mem_slot, src2);

  // Without forwarding, any EXE/MEM producer stalls; WB is safe because the
  // register file writes before it reads. With forwarding, only load-use stalls.
  always_comb begin
    hazard = 1'b0;
    if (!fwd_en) begin
      hazard = (src1_matters && (exe_w1 || mem_w1)) ||
               (src2_matters && (exe_w2 || mem_w2));
    end else begin
      hazard = exe_slot.mem_r &&
               ((src1_matters && exe_w1) || (src2_matters && exe_w2));
    end
  end

  assign bubble = hazard || !bus.id_valid;

  // The EXE producer is the newest, so it takes priority over MEM.
  always_comb begin
    sel1_next = FWD_REG;
    sel2_next = FWD_REG;
    if (fwd_en) begin
      if (src1_matters) begin
        if (exe_w1)      sel1_next = FWD_MEM;
        else if (mem_w1) sel1_next = FWD_WB;
      end
      if (src2_matters) begin
        if (exe_w2)      sel2_next = FWD_MEM;
        else if (mem_w2) sel2_next = FWD_WB;
      end
    end
  end

  always_comb begin
    entry       = SLOT_BUBBLE;
    entry.valid = 1'b1;
    entry.dest  = widen(bus.id_dest);
    entry.wb_en = bus.id_wb_en;
    entry.mem_r = bus.id_mem_r_en;
  end

  hazard_slot_pipe u_slots (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .bubble (bubble),
    .entry  (entry),
    .exe    (exe_slot),
    .mem    (mem_slot),
    .wb     (wb_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel1_q <= FWD_REG;
      sel2_q <= FWD_REG;
    end else if (!freeze) begin
      sel1_q <= bubble ? FWD_REG : sel1_next;
      sel2_q <= bubble ? FWD_REG : sel2_next;
    end
  end

  // WB contents and the MEM load flag are tracked for completeness only.
  assign unused_ok = ^{wb_slot, mem_slot.mem_r};

  assign bus.hazard_detected = hazard;
  assign bus.fwd_sel1        = sel1_q;
  assign bus.fwd_sel2        = sel2_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: a history-queue reference model
// predicts stall and select values; a monitor process checks them per cycle.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst;
  logic fwd_en;
  logic freeze;

  hazard_fwd_if #(.REG_ADDR_W(5)) bus ();

  hazard_fwd_unit #(.REG_ADDR_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .fwd_en (fwd_en),
    .freeze (freeze),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int dest;
    bit wb_en;
    bit mem_r;
  } inst_t;

  typedef struct {
    bit       hz;
    bit [1:0] s1;
    bit [1:0] s2;
  } exp_t;

  // hist[0] is the instruction in EXE, hist[1] in MEM, hist[2] in WB.
  inst_t    hist[$];
  bit [1:0] m_sel1 = 2'b00;
  bit [1:0] m_sel2 = 2'b00;
  exp_t     exp_q[$];
  int       n_compared   = 0;
  int       n_mismatched = 0;
  bit       cur_fe       = 1'b0;

  function automatic bit writes(inst_t s, int r);
    return s.valid && s.wb_en && (s.dest == r) && (r != 0);
  endfunction

  function automatic bit [1:0] pick_sel(bit fe, bit matters, int r, inst_t e, inst_t m);
    if (!fe || !matters) return 2'b00;
    if (writes(e, r))    return 2'b01;
    if (writes(m, r))    return 2'b10;
    return 2'b00;
  endfunction

  task automatic applyStimulus(input bit r_i, input bit fe, input bit fz, input bit v,
                               input int s1, input int s2, input bit two,
                               input int d, input bit wb, input bit mr);
    exp_t  e;
    inst_t bub;
    inst_t ins;
    bit    m1, m2, hz;
    @(negedge clk);
    rst             = r_i;
    fwd_en          = fe;
    freeze          = fz;
    bus.id_valid    = v;
    bus.id_src1     = 5'(s1);
    bus.id_src2     = 5'(s2);
    bus.id_two_src  = two;
    bus.id_dest     = 5'(d);
    bus.id_wb_en    = wb;
    bus.id_mem_r_en = mr;

    m1 = v && (s1 != 0);
    m2 = v && two && (s2 != 0);
    if (!fe)
      hz = (m1 && (writes(hist[0], s1) || writes(hist[1], s1))) ||
           (m2 && (writes(hist[0], s2) || writes(hist[1], s2)));
    else
      hz = hist[0].mem_r && ((m1 && writes(hist[0], s1)) || (m2 && writes(hist[0], s2)));

    bub = '{valid: 1'b0, dest: 0, wb_en: 1'b0, mem_r: 1'b0};
    if (r_i) begin
      hist   = '{bub, bub, bub};
      m_sel1 = 2'b00;
      m_sel2 = 2'b00;
    end else if (!fz) begin
      if (hz || !v) begin
        m_sel1 = 2'b00;
        m_sel2 = 2'b00;
        hist.push_front(bub);
      end else begin
        m_sel1 = pick_sel(fe, m1, s1, hist[0], hist[1]);
        m_sel2 = pick_sel(fe, m2, s2, hist[0], hist[1]);
        ins = '{valid: 1'b1, dest: d, wb_en: wb, mem_r: mr};
        hist.push_front(ins);
      end
      void'(hist.pop_back());
    end
    e.hz = hz;
    e.s1 = m_sel1;
    e.s2 = m_sel2;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int s1, input int s2, input bit two,
                       input int d, input bit wb, input bit mr);
    applyStimulus(1'b0, cur_fe, 1'b0, 1'b1, s1, s2, two, d, wb, mr);
  endtask

  task automatic doReset(input bit fe);
    cur_fe = fe;
    applyStimulus(1'b1, fe, 1'b0, 1'b1, 7, 9, 1'b1, 7, 1'b1, 1'b1);
  endtask

  task automatic checkOutput(input exp_t e, input logic hz, input logic [1:0] s1,
                             input logic [1:0] s2);
    n_compared++;
    if (hz !== e.hz) begin
      n_mismatched++;
      $display("[TB] FAIL hazard_detected @%0t: got %b expected %b", $time, hz, e.hz);
    end
    n_compared++;
    if (s1 !== e.s1) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_sel1 @%0t: got %b expected %b", $time, s1, e.s1);
    end
    n_compared++;
    if (s2 !== e.s2) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_sel2 @%0t: got %b expected %b", $time, s2, e.s2);
    end
  endtask

  // Monitor: stall is sampled just before the edge, selects just after it.
  initial begin
    exp_t e;
    logic hz_s;
    forever begin
      @(negedge clk);
      #4;
      hz_s = bus.hazard_detected;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e, hz_s, bus.fwd_sel1, bus.fwd_sel2);
      end
    end
  end

  initial begin
    inst_t bub;
    int    waited;
    bub  = '{valid: 1'b0, dest: 0, wb_en: 1'b0, mem_r: 1'b0};
    hist = '{bub, bub, bub};
    rst = 1'b1; fwd_en = 1'b0; freeze = 1'b0;
    bus.id_valid = 1'b0; bus.id_src1 = '0; bus.id_src2 = '0; bus.id_two_src = 1'b0;
    bus.id_dest = '0; bus.id_wb_en = 1'b0; bus.id_mem_r_en = 1'b0;
    @(posedge clk);
    $display("[TB] start");

    doReset(1'b0);
    doReset(1'b0);

    // No forwarding: consumer stalls while producer sits in EXE and MEM.
    issue(1, 2, 1'b1, 3, 1'b1, 1'b0);
    repeat (3) issue(3, 0, 1'b0, 4, 1'b1, 1'b0);

    // Forwarding: back-to-back and one-apart ALU dependencies.
    doReset(1'b1);
    issue(1, 2, 1'b1, 3, 1'b1, 1'b0);
    issue(3, 3, 1'b1, 4, 1'b1, 1'b0);
    issue(1, 2, 1'b1, 3, 1'b1, 1'b0);
    issue(1, 2, 1'b0, 6, 1'b1, 1'b0);
    issue(3, 3, 1'b1, 7, 1'b1, 1'b0);

    // Load-use: one stall, then store data forwarded from WB.
    issue(1, 0, 1'b0, 5, 1'b1, 1'b1);
    repeat (2) issue(1, 5, 1'b1, 0, 1'b0, 1'b0);

    // Register zero and an unread src2 never stall.
    issue(1, 0, 1'b0, 0, 1'b1, 1'b1);
    issue(0, 0, 1'b1, 2, 1'b1, 1'b0);
    issue(1, 0, 1'b0, 4, 1'b1, 1'b1);
    issue(2, 4, 1'b0, 6, 1'b1, 1'b0);
    issue(2, 2, 1'b1, 2, 1'b1, 1'b0);

    // Load-use held under freeze, then released.
    issue(1, 0, 1'b0, 5, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1, 5, 1'b1, 0, 1'b0, 1'b0);
    repeat (2) issue(1, 5, 1'b1, 0, 1'b0, 1'b0);

    // Reset while a stall is pending.
    issue(1, 0, 1'b0, 5, 1'b1, 1'b1);
    issue(5, 0, 1'b0, 6, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5, 0, 1'b0, 6, 1'b1, 1'b0);
    issue(5, 0, 1'b0, 6, 1'b1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 2) begin
        doReset(1'($urandom_range(1)));
      end else begin
        applyStimulus(1'b0, cur_fe, $urandom_range(99) < 10, $urandom_range(99) < 85,
                      int'($urandom_range(4)), int'($urandom_range(4)), 1'($urandom_range(1)),
                      int'($urandom_range(4)), $urandom_range(99) < 80,
                      $urandom_range(99) < 30);
      end
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
